// File: rtl/abc80_tape_pkg.sv
package abc80_tape_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOCKING = 2'd1,
    LOCKED  = 2'd2
  } tape_state_t;

  localparam int unsigned FILT_CYCLES_DEF = 24;
  localparam int unsigned MIN_HALF_DEF    = 600;
  localparam int unsigned MAX_HALF_DEF    = 24000;
  localparam int unsigned LOCK_EDGES_DEF  = 8;
  localparam int unsigned LOSS_EDGES_DEF  = 4;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == '1) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/abc80_tape_in_if.sv
interface abc80_tape_in_if;

  logic        tape_raw;
  logic        enable;
  logic        cass_in;
  logic        edge_stb;
  logic [15:0] half_period;
  logic        period_valid;
  logic        carrier;
  logic        tape_snd;

  modport master (
    output tape_raw, enable,
    input  cass_in, edge_stb, half_period, period_valid, carrier, tape_snd
  );

  modport slave (
    input  tape_raw, enable,
    output cass_in, edge_stb, half_period, period_valid, carrier, tape_snd
  );

endinterface

// File: rtl/abc80_tape_in_glitch_filter.sv
module abc80_glitch_filter
  import abc80_tape_pkg::*;
#(
  parameter int unsigned FILT_CYCLES = FILT_CYCLES_DEF
) (
  input  logic clk_sys,
  input  logic reset_n,
  input  logic tape_raw,
  output logic cass_in,
  output logic edge_stb,
  output logic edge_pre
);

  logic       s1_q, s1_d;
  logic       s2_q, s2_d;
  logic       lvl_q, lvl_d;
  logic       tog_q, tog_d;
  logic       cass_q, cass_d;
  logic       edge_q, edge_d;
  logic [7:0] fc_q, fc_d;
  logic       mism;
  logic       fire;

  // Filter decisions are made on lvl; cass_in/edge_stb are the same
  // decisions one register later, so edge_pre lets the meter capture in
  // the very cycle cass_in changes.
  always_comb begin
    s1_d   = tape_raw;
    s2_d   = s1_q;
    mism   = s2_q ^ lvl_q;
    fire   = mism && (fc_q == 8'(FILT_CYCLES - 1));
    fc_d   = (mism && !fire) ? fc_q + 8'd1 : '0;
    lvl_d  = lvl_q ^ fire;
    tog_d  = fire;
    cass_d = lvl_q;
    edge_d = tog_q;
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      s1_q   <= 1'b0;
      s2_q   <= 1'b0;
      fc_q   <= '0;
      lvl_q  <= 1'b0;
      tog_q  <= 1'b0;
      cass_q <= 1'b0;
      edge_q <= 1'b0;
    end else begin
      s1_q   <= s1_d;
      s2_q   <= s2_d;
      fc_q   <= fc_d;
      lvl_q  <= lvl_d;
      tog_q  <= tog_d;
      cass_q <= cass_d;
      edge_q <= edge_d;
    end
  end

  assign cass_in  = cass_q;
  assign edge_stb = edge_q;
  assign edge_pre = tog_q;

endmodule

// File: rtl/abc80_tape_in.sv
module abc80_tape_in
  import abc80_tape_pkg::*;
#(
  parameter int unsigned FILT_CYCLES = FILT_CYCLES_DEF,
  parameter int unsigned MIN_HALF    = MIN_HALF_DEF,
  parameter int unsigned MAX_HALF    = MAX_HALF_DEF,
  parameter int unsigned LOCK_EDGES  = LOCK_EDGES_DEF,
  parameter int unsigned LOSS_EDGES  = LOSS_EDGES_DEF
) (
  input  logic           clk_sys,
  input  logic           reset_n,
  abc80_tape_in_if.slave tif
);

  logic cass_w;
  logic edge_stb_w;
  logic edge_pre;

  abc80_glitch_filter #(
    .FILT_CYCLES(FILT_CYCLES)
  ) u_filt (
    .clk_sys (clk_sys),
    .reset_n (reset_n),
    .tape_raw(tif.tape_raw),
    .cass_in (cass_w),
    .edge_stb(edge_stb_w),
    .edge_pre(edge_pre)
  );

  logic [15:0] pc_q, pc_d;
  logic [15:0] half_q, half_d;
  logic        pv_q, pv_d;
  logic        snd_q, snd_d;
  logic [15:0] hp_now;
  logic        edge_ok;
  logic        timeout;

  tape_state_t state_q, state_d;
  logic [3:0]  lk_q, lk_d;
  logic [3:0]  ls_q, ls_d;
  logic [3:0]  lk_inc, ls_inc;
  logic        armed_q, armed_d;
  logic        carrier;

  // An edge coinciding with pc == MAX_HALF wins; the timeout is suppressed.
  always_comb begin
    hp_now  = sat_inc16(pc_q);
    edge_ok = armed_q && (hp_now >= 16'(MIN_HALF)) && (hp_now <= 16'(MAX_HALF));
    timeout = !edge_pre && (pc_q == 16'(MAX_HALF));
    pc_d    = edge_pre ? '0 : hp_now;
    half_d  = edge_pre ? hp_now : half_q;
    pv_d    = edge_pre ? edge_ok : pv_q;
    snd_d   = cass_w & carrier;
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      pc_q   <= '0;
      half_q <= '0;
      pv_q   <= 1'b0;
      snd_q  <= 1'b0;
    end else begin
      pc_q   <= pc_d;
      half_q <= half_d;
      pv_q   <= pv_d;
      snd_q  <= snd_d;
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      lk_q    <= '0;
      ls_q    <= '0;
      armed_q <= 1'b0;
    end else begin
      state_q <= state_d;
      lk_q    <= lk_d;
      ls_q    <= ls_d;
      armed_q <= armed_d;
    end
  end

  always_comb begin
    state_d = state_q;
    lk_d    = lk_q;
    ls_d    = ls_q;
    armed_d = armed_q;
    lk_inc  = lk_q + 4'd1;
    ls_inc  = ls_q + 4'd1;
    if (!tif.enable) begin
      state_d = IDLE;
      lk_d    = '0;
      ls_d    = '0;
      armed_d = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (edge_pre) begin
            armed_d = 1'b1;
            if (edge_ok) begin
              state_d = LOCKING;
              lk_d    = 4'd1;
            end
          end
        end
        LOCKING: begin
          if (edge_pre) begin
            if (edge_ok) begin
              lk_d = lk_inc;
              if (lk_inc == 4'(LOCK_EDGES)) begin
                state_d = LOCKED;
                ls_d    = '0;
              end
            end else begin
              state_d = IDLE;
              lk_d    = '0;
              ls_d    = '0;
              armed_d = 1'b0;
            end
          end else if (timeout) begin
            state_d = IDLE;
            lk_d    = '0;
            ls_d    = '0;
            armed_d = 1'b0;
          end
        end
        LOCKED: begin
          if (edge_pre) begin
            if (edge_ok) begin
              ls_d = '0;
            end else if (ls_inc == 4'(LOSS_EDGES)) begin
              state_d = IDLE;
              lk_d    = '0;
              ls_d    = '0;
              armed_d = 1'b0;
            end else begin
              ls_d = ls_inc;
            end
          end else if (timeout) begin
            state_d = IDLE;
            lk_d    = '0;
            ls_d    = '0;
            armed_d = 1'b0;
          end
        end
        default: begin
          state_d = IDLE;
          lk_d    = '0;
          ls_d    = '0;
          armed_d = 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    carrier = (state_q == LOCKED);
  end

  assign tif.cass_in      = cass_w;
  assign tif.edge_stb     = edge_stb_w;
  assign tif.half_period  = half_q;
  assign tif.period_valid = pv_q;
  assign tif.carrier      = carrier;
  assign tif.tape_snd     = snd_q;

endmodule

// File: tb/tb_abc80_tape_in.sv
module tb_abc80_tape_in;

  localparam int unsigned FILT  = 24;
  localparam int unsigned MINH  = 60;
  localparam int unsigned MAXH  = 2400;
  localparam int unsigned LOCKN = 8;
  localparam int unsigned LOSSN = 4;
  localparam int unsigned LAT   = FILT + 2;
  localparam int unsigned H     = 857;
  localparam int unsigned SHORT = 30;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  abc80_tape_in_if tif();

  abc80_tape_in #(
    .FILT_CYCLES(FILT),
    .MIN_HALF   (MINH),
    .MAX_HALF   (MAXH),
    .LOCK_EDGES (LOCKN),
    .LOSS_EDGES (LOSSN)
  ) dut (
    .clk_sys(clk),
    .reset_n(rst_n),
    .tif    (tif.slave)
  );

  typedef struct {
    logic        cass;
    logic [15:0] hp;
    bit          chk_hp;
    logic        pv;
    logic        car;
  } exp_t;

  exp_t        sb[$];
  int unsigned cyc = 0;
  int unsigned last_land = 0;
  bit          has_prev = 1'b0;
  int          checks = 0;
  int          errors = 0;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Called at a negedge: the new level lands in sync flop 1 at the next posedge.
  task automatic toggle(input logic pv, input logic car);
    exp_t        e;
    int unsigned land;
    int unsigned d;
    land     = cyc + 1;
    d        = land - last_land;
    e.cass   = ~tif.tape_raw;
    e.chk_hp = has_prev;
    e.hp     = (d > 65535) ? 16'hFFFF : 16'(d);
    e.pv     = pv;
    e.car    = car;
    sb.push_back(e);
    tif.tape_raw = ~tif.tape_raw;
    last_land    = land;
    has_prev     = 1'b1;
  endtask

  task automatic run_lock();
    toggle(1'b0, 1'b0);
    for (int unsigned k = 2; k <= LOCKN + 1; k++) begin
      repeat (H) @(negedge clk);
      toggle(1'b1, k == LOCKN + 1);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && tif.edge_stb) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_edge: edge_stb at cycle %0d, none expected", cyc);
      end else begin
        e = sb.pop_front();
        chk("edge_cass_in", {31'd0, tif.cass_in}, {31'd0, e.cass});
        if (e.chk_hp) chk("edge_half_period", {16'd0, tif.half_period}, {16'd0, e.hp});
        chk("edge_period_valid", {31'd0, tif.period_valid}, {31'd0, e.pv});
        chk("edge_carrier", {31'd0, tif.carrier}, {31'd0, e.car});
      end
    end
  end

  initial begin
    int unsigned hi;
    int unsigned e_pos;
    tif.tape_raw = 1'b0;
    tif.enable   = 1'b0;
    rst_n        = 1'b0;
    repeat (4) @(negedge clk);
    chk("rst_cass_in", {31'd0, tif.cass_in}, 0);
    chk("rst_edge_stb", {31'd0, tif.edge_stb}, 0);
    chk("rst_half_period", {16'd0, tif.half_period}, 0);
    chk("rst_period_valid", {31'd0, tif.period_valid}, 0);
    chk("rst_carrier", {31'd0, tif.carrier}, 0);
    chk("rst_tape_snd", {31'd0, tif.tape_snd}, 0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    toggle(1'b0, 1'b0);
    repeat (LAT) @(negedge clk);
    chk("latency_before", {31'd0, tif.cass_in}, 0);
    @(negedge clk);
    chk("latency_at", {31'd0, tif.cass_in}, 1);
    repeat (40) @(negedge clk);
    toggle(1'b0, 1'b0);
    repeat (60) @(negedge clk);

    hi = 0;
    for (int unsigned i = 0; i < 100; i++) begin
      if (i == 0) tif.tape_raw = 1'b1;
      if (i == FILT - 1) tif.tape_raw = 1'b0;
      if (tif.cass_in) hi++;
      @(negedge clk);
    end
    chk("pulse_short_high_cycles", hi, 0);

    hi = 0;
    for (int unsigned i = 0; i < 100; i++) begin
      if (i == 0) toggle(1'b0, 1'b0);
      if (i == FILT) toggle(1'b0, 1'b0);
      if (tif.cass_in) hi++;
      @(negedge clk);
    end
    chk("pulse_min_high_cycles", hi, FILT);

    tif.enable = 1'b1;
    repeat (10) @(negedge clk);
    run_lock();

    for (int unsigned k = 0; k < LOSSN - 1; k++) begin
      repeat (SHORT) @(negedge clk);
      toggle(1'b0, 1'b1);
    end
    repeat (H) @(negedge clk);
    toggle(1'b1, 1'b1);

    for (int unsigned k = 1; k <= LOSSN; k++) begin
      repeat (SHORT) @(negedge clk);
      toggle(1'b0, k != LOSSN);
    end

    repeat (H) @(negedge clk);
    run_lock();

    e_pos = last_land + LAT;
    while (cyc < e_pos + MAXH) @(negedge clk);
    chk("carrier_before_timeout", {31'd0, tif.carrier}, 1);
    @(negedge clk);
    chk("carrier_after_timeout", {31'd0, tif.carrier}, 0);

    repeat (5) @(negedge clk);
    run_lock();
    repeat (40) @(negedge clk);
    chk("locked_cass_in", {31'd0, tif.cass_in}, 1);
    chk("locked_tape_snd", {31'd0, tif.tape_snd}, 1);

    tif.enable = 1'b0;
    @(negedge clk);
    chk("disable_carrier", {31'd0, tif.carrier}, 0);
    @(negedge clk);
    chk("disable_tape_snd", {31'd0, tif.tape_snd}, 0);

    toggle(1'b0, 1'b0);
    repeat (60) @(negedge clk);
    chk("disabled_cass_follows", {31'd0, tif.cass_in}, 0);
    chk("disabled_tape_snd", {31'd0, tif.tape_snd}, 0);
    chk("scoreboard_drained", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
